// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared types and constants for the two-source packet
// arbiter (mux2_arbiter) and its select datapath (mux2_datapath).
package mux2_arb_pkg;

  // Arbiter state: idle, or one source owning the output channel.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT0 = 2'b01,
    ST_GRANT1 = 2'b10
  } arb_state_e;

  // Mux select encodings: which source drives the output.
  localparam logic SEL_SRC0 = 1'b0;
  localparam logic SEL_SRC1 = 1'b1;

  // The opposite source of the one given.
  function automatic logic other_sel(input logic sel);
    return (sel == SEL_SRC1) ? SEL_SRC0 : SEL_SRC1;
  endfunction

  // Grant state that gives the channel to the given source.
  function automatic arb_state_e grant_state(input logic sel);
    return (sel == SEL_SRC1) ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/mux2_arbiter_if.sv
// mux2_arbiter_if: bundle of the two source channels and the downstream
// channel around the arbiter. The slave modport is the arbiter's view;
// the master modport is the view of the sources plus the consumer.
interface mux2_arbiter_if #(
  parameter int WIDTH = 8
);

  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             last0;
  logic             last1;
  logic             gnt0;
  logic             gnt1;
  logic             s;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_last;
  logic             y_ready;

  // Arbiter side: consumes requests and downstream ready, drives the rest.
  modport slave (
    input  req0, req1, data0, data1, last0, last1, y_ready,
    output gnt0, gnt1, s, y_valid, y_data, y_last
  );

  // Source/consumer side: drives requests, beats and ready.
  modport master (
    output req0, req1, data0, data1, last0, last1, y_ready,
    input  gnt0, gnt1, s, y_valid, y_data, y_last
  );

endinterface

// File: rtl/mux2_datapath.sv
// mux2_datapath: purely combinational 2:1 mux of {last, data}. The select
// is owned by the arbiter; this block adds no latency.
module mux2_datapath
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           sel,
  input  logic [WIDTH:0] in0,
  input  logic [WIDTH:0] in1,
  output logic [WIDTH:0] out
);

  // Pick the {last, data} word of the selected source.
  always_comb begin
    if (sel == SEL_SRC1) begin
      out = in1;
    end else begin
      out = in0;
    end
  end

endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin packet arbiter in front of a shared 2:1 mux.
// One source owns the downstream valid/ready channel for a whole packet;
// ownership alternates when both sources want it, and the next packet can
// start on the cycle right after the previous last beat is accepted.
//
// Optional feature macro: MUX2ARB_BURST_LIMIT_EN
//   When defined, a beat counter forces a hand-over to the other source
//   after MAX_BURST accepted beats, as long as that source is requesting.
//   The interrupted packet resumes on its next grant.
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic           clk,
  input  logic           rst,
  mux2_arbiter_if.slave  bus
);

  // A zero beat limit would make the burst feature meaningless.
  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("mux2_arbiter: MAX_BURST must be at least 1");
  end

  arb_state_e     state_r;
  arb_state_e     state_nxt_s;
  logic           ptr_r;       // source that wins a simultaneous request
  logic           ptr_nxt_s;
  logic           s_r;         // mux select, holds its value while idle
  logic           s_nxt_s;

  logic           gnt0_s;
  logic           gnt1_s;
  logic           granted_s;   // some source owns the channel
  logic           cur_src_s;   // owner of the channel while granted
  logic           cur_req_s;   // request of the owner
  logic           other_req_s; // request of the non-owner
  logic           y_valid_s;
  logic           acc_s;
  logic           end_pkt_s;
  logic           burst_hit_s;

  logic [WIDTH:0] mux_in0_s;
  logic [WIDTH:0] mux_in1_s;
  logic [WIDTH:0] mux_out_s;

  // ------------------------------------------------------------------
  // Datapath: zero-latency select of {last, data}
  // ------------------------------------------------------------------
  assign mux_in0_s = {bus.last0, bus.data0};
  assign mux_in1_s = {bus.last1, bus.data1};

  mux2_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .sel (s_r),
    .in0 (mux_in0_s),
    .in1 (mux_in1_s),
    .out (mux_out_s)
  );

  // ------------------------------------------------------------------
  // Handshake decode
  // ------------------------------------------------------------------

  // Decode the current owner and the requests seen from its point of view.
  always_comb begin
    granted_s   = 1'b0;
    cur_src_s   = SEL_SRC0;
    cur_req_s   = 1'b0;
    other_req_s = 1'b0;
    case (state_r)
      ST_GRANT0: begin
        granted_s   = 1'b1;
        cur_src_s   = SEL_SRC0;
        cur_req_s   = bus.req0;
        other_req_s = bus.req1;
      end
      ST_GRANT1: begin
        granted_s   = 1'b1;
        cur_src_s   = SEL_SRC1;
        cur_req_s   = bus.req1;
        other_req_s = bus.req0;
      end
      ST_IDLE: begin
        granted_s   = 1'b0;
      end
      default: begin
        granted_s   = 1'b0;
      end
    endcase
  end

  // A beat moves when the owner presents one and the consumer takes it;
  // the packet ends on its last beat or when the burst limit cuts it.
  assign acc_s     = y_valid_s & bus.y_ready;
  assign end_pkt_s = acc_s & (mux_out_s[WIDTH] | burst_hit_s);

`ifdef MUX2ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] cnt_r;

  // Cut the grant when this accepted beat reaches the limit and the
  // other source is waiting; otherwise the owner keeps the channel.
  always_comb begin
    if (acc_s && other_req_s && (cnt_r >= CNT_W'(MAX_BURST - 1))) begin
      burst_hit_s = 1'b1;
    end else begin
      burst_hit_s = 1'b0;
    end
  end

  // Beats accepted under the current grant; restarts on any grant change
  // or packet end, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (end_pkt_s || (state_nxt_s != state_r)) begin
      cnt_r <= '0;
    end else if (acc_s && (cnt_r != CNT_W'(MAX_BURST))) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  assign burst_hit_s = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Arbitration FSM
  // ------------------------------------------------------------------

  // State register: owner, tie-break pointer and held mux select.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= SEL_SRC0;
      s_r     <= SEL_SRC0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      s_r     <= s_nxt_s;
    end
  end

  // Next owner: arbitrate from idle, hand over only at packet end.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_nxt_s = grant_state(ptr_r);
        end else if (bus.req0) begin
          state_nxt_s = ST_GRANT0;
        end else if (bus.req1) begin
          state_nxt_s = ST_GRANT1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (end_pkt_s) begin
          // The other source wins the next tie whether or not it takes
          // the channel right now.
          ptr_nxt_s = other_sel(cur_src_s);
          if (other_req_s) begin
            state_nxt_s = grant_state(other_sel(cur_src_s));
          end else if (cur_req_s) begin
            state_nxt_s = grant_state(cur_src_s);
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ptr_nxt_s   = SEL_SRC0;
      end
    endcase
  end

  // Mux select follows the next owner and holds while idle.
  always_comb begin
    case (state_nxt_s)
      ST_GRANT0: s_nxt_s = SEL_SRC0;
      ST_GRANT1: s_nxt_s = SEL_SRC1;
      ST_IDLE:   s_nxt_s = s_r;
      default:   s_nxt_s = s_r;
    endcase
  end

  // Grants and output valid decoded from the owner state.
  always_comb begin
    gnt0_s    = 1'b0;
    gnt1_s    = 1'b0;
    y_valid_s = 1'b0;
    case (state_r)
      ST_GRANT0: begin
        gnt0_s    = 1'b1;
        y_valid_s = bus.req0;
      end
      ST_GRANT1: begin
        gnt1_s    = 1'b1;
        y_valid_s = bus.req1;
      end
      ST_IDLE: begin
        y_valid_s = 1'b0;
      end
      default: begin
        y_valid_s = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Output drive
  // ------------------------------------------------------------------
  assign bus.gnt0    = gnt0_s;
  assign bus.gnt1    = gnt1_s;
  assign bus.s       = s_r;
  assign bus.y_valid = y_valid_s & granted_s;
  assign bus.y_data  = mux_out_s[WIDTH-1:0];
  assign bus.y_last  = mux_out_s[WIDTH];

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: randomized scoreboard bench for mux2_arbiter.
// Sources hold packets as queues of beats; a packet-level model decides
// who owns the channel each cycle and pushes the expected control outputs
// and accepted beats, which a negedge monitor pops and compares.
module tb_mux2_arbiter;

  localparam int WIDTH = 8;
`ifdef MUX2ARB_BURST_LIMIT_EN
  localparam int MAX_BURST = 2;
`else
  localparam int MAX_BURST = 16;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  typedef struct packed {
    logic gnt0;
    logic gnt1;
    logic s;
    logic valid;
  } ctrl_t;

  typedef struct packed {
    logic             src;
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mux2_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux2_arbiter #(
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Source backlogs and scoreboard queues.
  beat_t     src_q [2][$];
  ctrl_t     ctrl_q [$];
  exp_beat_t beat_q [$];

  int vectors     = 0;
  int miscompares = 0;

  // Model: owner of the channel (-1 none), tie-break pointer, held select.
  int   owner   = -1;
  int   ptr_m   = 0;
  logic s_m     = 1'b0;
  int   beats_m = 0;

  // Stimulus knobs.
  int p_req [2];
  int p_ready   = 100;
  int p_rst     = 0;
  bit refill    = 1'b0;
  bit force_rst = 1'b0;

  // Append one packet of n beats; data is base*(k+1) or random.
  task automatic push_packet(input int src, input int n,
                             input logic [WIDTH-1:0] base, input bit rnd);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = rnd ? WIDTH'($urandom) : base * WIDTH'(k + 1);
      b.last = (k == n - 1);
      src_q[src].push_back(b);
    end
  endtask

  // Drive one cycle per iteration, predict its outputs, advance the model.
  task automatic run_cycles(input int n);
    bit    r [2];
    bit    rdy, valid, acc, endp, rst_now;
    beat_t head;
    ctrl_t c;
    exp_beat_t e;
    int    nxt;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (refill && src_q[i].size() == 0)
          push_packet(i, $urandom_range(1, 5), '0, 1'b1);
        r[i] = (src_q[i].size() > 0) && ($urandom_range(0, 99) < p_req[i]);
      end
      bus.req0  = r[0];
      bus.req1  = r[1];
      bus.data0 = (src_q[0].size() > 0) ? src_q[0][0].data : WIDTH'($urandom);
      bus.last0 = (src_q[0].size() > 0) ? src_q[0][0].last : 1'b0;
      bus.data1 = (src_q[1].size() > 0) ? src_q[1][0].data : WIDTH'($urandom);
      bus.last1 = (src_q[1].size() > 0) ? src_q[1][0].last : 1'b0;
      rdy         = ($urandom_range(0, 99) < p_ready);
      bus.y_ready = rdy;
      rst_now     = force_rst || ($urandom_range(0, 999) < p_rst);
      rst         = rst_now;

      valid   = (owner >= 0) && r[owner];
      acc     = valid && rdy;
      c.gnt0  = (owner == 0);
      c.gnt1  = (owner == 1);
      c.s     = s_m;
      c.valid = valid;
      ctrl_q.push_back(c);
      if (acc) begin
        head   = src_q[owner][0];
        e.src  = (owner == 1);
        e.data = head.data;
        e.last = head.last;
        beat_q.push_back(e);
      end

      @(posedge clk);
      if (rst_now) begin
        owner   = -1;
        ptr_m   = 0;
        s_m     = 1'b0;
        beats_m = 0;
        src_q[0].delete();
        src_q[1].delete();
      end else if (owner < 0) begin
        if (r[0] && r[1]) owner = ptr_m;
        else if (r[0])    owner = 0;
        else if (r[1])    owner = 1;
        else              owner = -1;
      end else begin
        endp = 1'b0;
        if (acc) begin
          endp = head.last;
`ifdef MUX2ARB_BURST_LIMIT_EN
          if ((beats_m + 1 >= MAX_BURST) && r[1 - owner]) endp = 1'b1;
`endif
          void'(src_q[owner].pop_front());
          beats_m++;
        end
        nxt = owner;
        if (endp) begin
          ptr_m   = 1 - owner;
          beats_m = 0;
          if (r[1 - owner]) nxt = 1 - owner;
          else if (r[owner]) nxt = owner;
          else nxt = -1;
        end
        owner = nxt;
      end
      if (owner >= 0) s_m = (owner == 1);
      #1;
    end
  endtask

  // Monitor: check control outputs every cycle and each accepted beat.
  always @(negedge clk) begin
    ctrl_t     c;
    exp_beat_t e;
    if (ctrl_q.size() > 0) begin
      c = ctrl_q.pop_front();
      vectors++;
      if ({bus.gnt0, bus.gnt1, bus.s, bus.y_valid} !== {c.gnt0, c.gnt1, c.s, c.valid}) begin
        miscompares++;
        $display("FAIL ctrl @%0t: gnt0,gnt1,s,y_valid got %b%b%b%b expected %b%b%b%b",
                 $time, bus.gnt0, bus.gnt1, bus.s, bus.y_valid,
                 c.gnt0, c.gnt1, c.s, c.valid);
      end
      if (bus.y_valid === 1'b1 && bus.y_ready === 1'b1) begin
        vectors++;
        if (beat_q.size() == 0) begin
          miscompares++;
          $display("FAIL beat @%0t: unexpected accept src=%b data=%h last=%b, none expected",
                   $time, bus.s, bus.y_data, bus.y_last);
        end else begin
          e = beat_q.pop_front();
          if ({bus.s, bus.y_data, bus.y_last} !== {e.src, e.data, e.last}) begin
            miscompares++;
            $display("FAIL beat @%0t: src/data/last got %b/%h/%b expected %b/%h/%b",
                     $time, bus.s, bus.y_data, bus.y_last, e.src, e.data, e.last);
          end
        end
      end
    end
  end

  initial begin
    bus.req0    = 1'b0;
    bus.req1    = 1'b0;
    bus.data0   = '0;
    bus.data1   = '0;
    bus.last0   = 1'b0;
    bus.last1   = 1'b0;
    bus.y_ready = 1'b0;
    p_req[0]    = 0;
    p_req[1]    = 0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single 3-beat packet on source 0.
    push_packet(0, 3, 8'h11, 1'b0);
    p_req[0] = 100; p_req[1] = 0; p_ready = 100;
    run_cycles(6);

    // Both sources from reset with 2-beat packets: strict alternation.
    force_rst = 1'b1; run_cycles(2); force_rst = 1'b0;
    push_packet(0, 2, 8'h21, 1'b0); push_packet(0, 2, 8'h41, 1'b0);
    push_packet(1, 2, 8'h31, 1'b0); push_packet(1, 2, 8'h51, 1'b0);
    p_req[0] = 100; p_req[1] = 100;
    run_cycles(10);

    // Backpressure for 4 cycles mid-packet.
    push_packet(0, 4, 8'h13, 1'b0);
    p_req[1] = 0;
    run_cycles(2);
    p_ready = 0;   run_cycles(4);
    p_ready = 100; run_cycles(5);

    // Source 1 drops req after its first beat while source 0 waits.
    push_packet(1, 3, 8'h07, 1'b0);
    p_req[0] = 0; p_req[1] = 100;
    run_cycles(2);
    push_packet(0, 2, 8'h05, 1'b0);
    p_req[0] = 100; p_req[1] = 0;
    run_cycles(2);
    p_req[1] = 100;
    run_cycles(8);

    // Reset while beat 2 of 4 is on the bus.
    push_packet(0, 4, 8'h09, 1'b0);
    p_req[1] = 0;
    run_cycles(2);
    force_rst = 1'b1; run_cycles(1); force_rst = 1'b0;
    run_cycles(3);

    // Randomized traffic with stalls, drops and occasional resets.
    refill = 1'b1;
    for (int ph = 0; ph < 8; ph++) begin
      p_req[0] = $urandom_range(30, 100);
      p_req[1] = $urandom_range(30, 100);
      p_ready  = $urandom_range(30, 100);
      p_rst    = (ph % 2 == 1) ? 3 : 0;
      run_cycles(250);
    end
    refill = 1'b0;
    p_rst  = 0;
    p_req[0] = 0; p_req[1] = 0;
    run_cycles(1);

    @(negedge clk);
    #1;
    vectors++;
    if (beat_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected beats never accepted, required 0", beat_q.size());
    end
    vectors++;
    if (ctrl_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d control checks pending, required 0", ctrl_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
